// File: rtl/sevseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevseg_scan_driver
//
// Time-multiplexed hex driver for a common-anode seven-segment bank.
// Captures a packed hex value with per-digit decimal points and enables into a
// pending register set. The pending set is copied into the display set at each
// frame boundary, so the visible image never tears. Each digit slot has PWM
// brightness and a one-cycle ghosting dead time at slot start. All pin outputs
// are registered and active-low.
//
// Optional feature macro: SEVSEG_LZB_EN (leading-zero blanking on the display
// set; digit 0 is never blanked, decimal points stay visible).
//
// Parameters:
//   DIGITS     number of scanned digits, 1..16
//   SCAN_DIV   clock cycles per digit slot, multiple of 8, >= 16
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        one-cycle strobe capturing value/dp_in/en_in into pending
//   value       packed nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point request per digit, active-high
//   en_in       digit enable per digit, active-high
//   bright      brightness 0..7, sampled every cycle
//   seg         segments g..a, active-low
//   dp          decimal point, active-low
//   an          anode selects, active-low, at most one low
//   frame_done  one-cycle pulse for the last cycle of the last digit slot
// -----------------------------------------------------------------------------
module sevseg_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    input  logic [2:0]            bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int                SLOT_W    = $clog2(SCAN_DIV);
    localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0]       PHASE_LEN = 32'(SCAN_DIV / 8);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    // Active-low g..a patterns for hex digits 0..F
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan counters
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Pending and display register sets
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_en_q, pend_en_d;
    logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]   disp_en_q, disp_en_d;

    // Registered pin drivers
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_wrap;
    logic                frame_end;
    logic [SLOT_W:0]     on_limit;
    logic                lit;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;

    assign slot_wrap = (slot_q == SLOT_LAST);
    assign frame_end = slot_wrap && (idx_q == IDX_LAST);

    // phase <= bright is equivalent to slot_cnt < (bright+1)*(SCAN_DIV/8),
    // which avoids a divider. Slot 0 is the dead time that hides ghosting.
    assign on_limit = (SLOT_W+1)'((32'(bright) + 32'd1) * PHASE_LEN);
    assign lit      = (slot_q != '0) && ({1'b0, slot_q} < on_limit);

`ifdef SEVSEG_LZB_EN
    // A digit above 0 is blank when it and every more-significant nibble are 0
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = ~|disp_val_q[4*DIGITS-1:4*gi];
            end
        end
    endgenerate
`else
    assign blank = '0;
`endif

    always_comb begin
        // counters
        slot_d = slot_wrap ? '0 : slot_q + 1'b1;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            idx_d = idx_q;
        end

        // pending set: last load in a frame wins
        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        pend_en_d  = load ? en_in : pend_en_q;

        // display set: swapped only at the frame boundary; a load on that
        // very cycle bypasses pending so it is not lost for a whole frame
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_en_d  = disp_en_q;
        if (frame_end) begin
            disp_val_d = pend_val_d;
            disp_dp_d  = pend_dp_d;
            disp_en_d  = pend_en_d;
        end

        // select current digit's data
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_val_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = blank[i];
            end
        end

        seg_d        = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
        dp_d         = ~cur_dp;
        frame_done_d = frame_end;
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
            assign an_d[gi] = ~((idx_q == IDX_W'(gi)) & disp_en_q[gi] & lit);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_en_q    <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_en_q    <= disp_en_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevseg_scan_driver
//
// Directed bench for sevseg_scan_driver with DIGITS=8, SCAN_DIV=16.
// Time base: t counts rising edges since reset release. Inputs driven just
// after edge t act on counter state t; outputs sampled just after edge t show
// the registered result of state t-1 (digit ((t-1)/16)%8, slot (t-1)%16).
// Expected pin values are queued with a target t and popped when reached.
// -----------------------------------------------------------------------------
module tb_sevseg_scan_driver;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 16;

`ifdef SEVSEG_LZB_EN
    localparam logic [6:0] ZB = 7'h7F;
`else
    localparam logic [6:0] ZB = 7'h40;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  en_in = '0;
    logic [2:0]  bright = 3'd7;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    sevseg_scan_driver #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .bright     (bright),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    typedef struct {
        int          t;
        bit          is_fd;
        logic [15:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   t = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic logic [6:0] seg_of(input int n);
        logic [6:0] s;
        case (n)
            0: s = 7'h40;  1: s = 7'h79;  2: s = 7'h24;  3: s = 7'h30;
            4: s = 7'h19;  5: s = 7'h12;  6: s = 7'h02;  7: s = 7'h78;
            8: s = 7'h00;  9: s = 7'h10; 10: s = 7'h08; 11: s = 7'h03;
            12: s = 7'h46; 13: s = 7'h21; 14: s = 7'h06; default: s = 7'h0E;
        endcase
        return s;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s t=%0d: got %h expected %h", tag, t, obs, exp);
        $display("check %s t=%0d obs=%h exp=%h", tag, t, obs, exp);
    endtask

    task automatic push_pins(input int tt, input string tag, input logic [7:0] a,
                             input logic [6:0] s, input logic d);
        exp_t e;
        e.t = tt; e.is_fd = 1'b0; e.exp = {a, s, d}; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_fd(input int tt, input logic f);
        exp_t e;
        e.t = tt; e.is_fd = 1'b1; e.exp = {15'b0, f}; e.tag = "frame_done";
        sb.push_back(e);
    endtask

    task automatic run_to(input int target);
        while (t < target) begin
            @(posedge clk);
            #1;
            t++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].t == t) begin
                    if (sb[i].is_fd) check(sb[i].tag, {15'b0, frame_done}, sb[i].exp);
                    else             check(sb[i].tag, {an, seg, dp}, sb[i].exp);
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic drive_load(input int at, input logic [31:0] v,
                              input logic [7:0] e, input logic [7:0] d);
        run_to(at);
        value = v; en_in = e; dp_in = d; load = 1'b1;
        run_to(at + 1);
        load = 1'b0;
    endtask

    initial begin
        logic [7:0] a;

        // reset state while held
        repeat (3) @(posedge clk);
        #1;
        check("reset_pins", {an, seg, dp}, 16'hFFFF);
        check("reset_fd", {15'b0, frame_done}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;

        // first frame_done exactly 128 cycles after release; dark display
        push_fd(127, 1'b0);
        push_fd(128, 1'b1);
        push_fd(129, 1'b0);
        push_pins(201, "dark_d4", 8'hFF, ZB, 1'b1);
        push_pins(245, "pending_not_shown", 8'hFF, ZB, 1'b1);
        // frame 2: value 12345678, en FF, dp 04
        push_pins(257, "dead_time_d0", 8'hFF, 7'h00, 1'b1);
        push_pins(259, "scan_d0", 8'hFE, 7'h00, 1'b1);
        push_pins(294, "scan_d2_dp", 8'hFB, 7'h02, 1'b0);
        push_pins(374, "scan_d7", 8'h7F, 7'h79, 1'b1);
        push_pins(384, "full_bright_last", 8'h7F, 7'h79, 1'b1);
        push_fd(256, 1'b1);
        push_fd(383, 1'b0);
        push_fd(384, 1'b1);
        drive_load(130, 32'h1234_5678, 8'hFF, 8'h04);

        // PWM: bright 3 on digit 3, bright 0 on digit 4 (frame 3)
        run_to(384);
        bright = 3'd3;
        for (int c = 0; c < 16; c++)
            push_pins(433 + c, "pwm_b3", (c >= 1 && c <= 7) ? 8'hF7 : 8'hFF, 7'h12, 1'b1);
        run_to(448);
        bright = 3'd0;
        for (int c = 0; c < 16; c++)
            push_pins(449 + c, "pwm_b0", (c == 1) ? 8'hEF : 8'hFF, 7'h19, 1'b1);
        run_to(464);
        bright = 3'd7;

        // tear-free: mid-frame load stays hidden, boundary load shows directly
        push_pins(598, "no_tear_d5", 8'hDF, 7'h30, 1'b1);
        push_pins(640, "no_tear_boundary", 8'h7F, 7'h79, 1'b1);
        drive_load(520, 32'hA5A5_A5A5, 8'hFF, 8'h00);
        push_pins(646, "boundary_load_d0", 8'hFE, 7'h24, 1'b1);
        push_pins(662, "boundary_load_d1", 8'hFD, 7'h30, 1'b1);
        push_pins(758, "boundary_load_d7", 8'h7F, 7'h10, 1'b1);
        drive_load(639, 32'h9876_5432, 8'hFF, 8'h00);

        // enables 0F: upper anodes dark, frame period unchanged (frame 6)
        for (int d = 0; d < 8; d++) begin
            a = (d < 4) ? ~(8'h01 << d) : 8'hFF;
            push_pins(774 + 16 * d, "en_mask", a, seg_of(d + 2), (d == 7) ? 1'b0 : 1'b1);
        end
        push_fd(768, 1'b1);
        push_fd(895, 1'b0);
        push_fd(896, 1'b1);
        drive_load(700, 32'h9876_5432, 8'h0F, 8'h80);

        // asynchronous reset mid-slot
        run_to(910);
        check("pre_reset_pins", {an, seg, dp}, {8'hFE, 7'h24, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_pins", {an, seg, dp}, 16'hFFFF);
        check("async_reset_fd", {15'b0, frame_done}, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = 0;

        // restart at digit 0 slot 0; blanking / zero display
        push_fd(127, 1'b0);
        push_fd(128, 1'b1);
        push_pins(20, "dark_after_reset", 8'hFF, ZB, 1'b1);
        for (int d = 0; d < 8; d++) begin
            a = ~(8'h01 << d);
            push_pins(134 + 16 * d, "lzb_0405", a,
                      (d == 0) ? 7'h12 : (d == 1) ? 7'h40 : (d == 2) ? 7'h19 : ZB, 1'b1);
        end
        drive_load(10, 32'h0000_0405, 8'hFF, 8'h00);
        push_pins(262, "lzb_zero_d0", 8'hFE, 7'h40, 1'b1);
        push_pins(278, "lzb_zero_d1", 8'hFD, ZB, 1'b1);
        push_pins(342, "lzb_zero_d5", 8'hDF, ZB, 1'b1);
        drive_load(200, 32'h0000_0000, 8'hFF, 8'h00);
        run_to(400);

        // anything still queued was never reached
        while (sb.size() > 0) begin
            total_cnt++;
            $error("FAIL %s unreached: got none expected %h at t=%0d", sb[0].tag, sb[0].exp, sb[0].t);
            void'(sb.pop_front());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
